// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT twiddle multiplier: default width, FSM states, counter width.
package ntt_pkg;

    localparam int unsigned DATA_SIZE = 8;
    localparam int unsigned CNT_W     = $clog2(DATA_SIZE);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        MUL,
        DONE
    } state_e;

endpackage

// File: rtl/ntt_mod_dbl_add.sv
// One interleaved double-and-add step: res = ((2*acc mod q) + bit_i*b) mod q, with acc, b < q.
module ntt_mod_dbl_add #(
    parameter int unsigned DATA_SIZE = 8
) (
    input  logic [DATA_SIZE-1:0] acc,
    input  logic [DATA_SIZE-1:0] b,
    input  logic [DATA_SIZE-1:0] q,
    input  logic                 bit_i,
    output logic [DATA_SIZE-1:0] res
);

    logic [DATA_SIZE:0] q_x;
    logic [DATA_SIZE:0] d;
    logic [DATA_SIZE:0] d_red;
    logic [DATA_SIZE:0] s;

    always_comb begin
        q_x   = {1'b0, q};
        d     = {acc, 1'b0};
        d_red = (d >= q_x) ? d - q_x : d;
        s     = bit_i ? d_red + {1'b0, b} : d_red;
        res   = (s >= q_x) ? DATA_SIZE'(s - q_x) : DATA_SIZE'(s);
    end

endmodule

// File: rtl/ntt_twiddle_mul.sv
// Bit-serial (MSB first) modular multiplier producing b*w mod q for an NTT butterfly,
// with valid/ready handshakes on input and output.
module ntt_twiddle_mul
    import ntt_pkg::*;
#(
    parameter int unsigned DATA_SIZE = ntt_pkg::DATA_SIZE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_SIZE-1:0] q,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_SIZE-1:0] a_in,
    input  logic [DATA_SIZE-1:0] b_in,
    input  logic [DATA_SIZE-1:0] w_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_SIZE-1:0] a_out,
    output logic [DATA_SIZE-1:0] bw_out
);

    localparam int unsigned IDX_W = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;

    state_e               state_q, state_d;
    logic                 live_q, live_d;
    logic [DATA_SIZE-1:0] a_q, a_d;
    logic [DATA_SIZE-1:0] b_q, b_d;
    logic [DATA_SIZE-1:0] w_q, w_d;
    logic [DATA_SIZE-1:0] q_q, q_d;
    logic [DATA_SIZE-1:0] acc_q, acc_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_SIZE-1:0] step_res;

    ntt_mod_dbl_add #(
        .DATA_SIZE(DATA_SIZE)
    ) u_step (
        .acc  (acc_q),
        .b    (b_q),
        .q    (q_q),
        .bit_i(w_q[idx_q]),
        .res  (step_res)
    );

    // live_q keeps in_ready low until the first edge after reset release
    assign in_ready  = live_q && (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign a_out     = a_q;
    assign bw_out    = acc_q;

    always_comb begin
        state_d = state_q;
        live_d  = 1'b1;
        a_d     = a_q;
        b_d     = b_q;
        w_d     = w_q;
        q_d     = q_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    w_d     = w_in;
                    q_d     = q;
                    acc_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                // q > 2^(N-1), so a single subtraction brings any N-bit b below q
                b_d     = (b_q >= q_q) ? b_q - q_q : b_q;
                idx_d   = IDX_W'(DATA_SIZE - 1);
                state_d = MUL;
            end
            MUL: begin
                acc_d = step_res;
                idx_d = idx_q - 1'b1;
                if (idx_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            live_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            w_q     <= '0;
            q_q     <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            live_q  <= live_d;
            a_q     <= a_d;
            b_q     <= b_d;
            w_q     <= w_d;
            q_q     <= q_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: tb/tb_ntt_twiddle_mul.sv
// Scoreboard bench for ntt_twiddle_mul: expected results are queued at accept and checked
// by an independent monitor when the result appears.
module tb_ntt_twiddle_mul;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] q;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a_in, b_in, w_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] a_out, bw_out;

    always #5 clk = ~clk;

    ntt_twiddle_mul #(
        .DATA_SIZE(8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .q        (q),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_in     (a_in),
        .b_in     (b_in),
        .w_in     (w_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .a_out    (a_out),
        .bw_out   (bw_out)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] bw;
        logic [7:0] q;
        int         acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    bit   rand_bp = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: on each new result, pop the oldest expectation and compare
    initial begin : monitor
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (out_valid && !prev) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result: got bw=%0d expected no output", bw_out);
                end else begin
                    e = sb.pop_front();
                    chk("a_out", a_out, e.a);
                    chk("bw_out", bw_out, e.bw);
                    chk("latency", cyc - e.acc_cyc, 9);
                    chk("bw_lt_q", int'(bw_out < e.q), 1);
                end
            end
            prev = out_valid;
        end
    end

    initial begin : bp_driver
        forever begin
            @(negedge clk);
            if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [7:0] w,
                        input logic [7:0] qq);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        a_in     = a;
        b_in     = b;
        w_in     = w;
        q        = qq;
        in_valid = 1'b1;
        while (!in_ready) begin
            n++;
            if (n > 200) begin
                total++;
                bad++;
                $display("FAIL accept_timeout: got in_ready=0 expected 1 within 200 cycles");
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        e.a       = a;
        e.bw      = 8'((int'(b) * int'(w)) % int'(qq));
        e.q       = qq;
        e.acc_cyc = cyc;
        sb.push_back(e);
        // Scramble inputs after accept; the operation in flight must ignore them
        in_valid = 1'b0;
        a_in     = 8'($urandom);
        b_in     = 8'($urandom);
        w_in     = 8'($urandom);
        q        = 8'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || !in_ready) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got pending=%0d expected 0", sb.size());
        end
    endtask

    initial begin : stim
        int n;
        logic [7:0] rq;
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a_in      = '0;
        b_in      = '0;
        w_in      = '0;
        q         = 8'd251;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_a_out", a_out, 0);
        chk("rst_bw_out", bw_out, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("in_ready_before_edge", in_ready, 0);
        @(posedge clk);
        #1;
        chk("in_ready_after_release", in_ready, 1);

        // Directed cases
        send(8'd17, 8'd200, 8'd200, 8'd251);
        send(8'd3, 8'd250, 8'd250, 8'd251);
        send(8'd4, 8'd255, 8'd3, 8'd251);
        send(8'd5, 8'd123, 8'd0, 8'd251);
        send(8'd6, 8'd0, 8'd255, 8'd251);
        send(8'd7, 8'd250, 8'd1, 8'd251);
        send(8'd8, 8'd255, 8'd255, 8'd251);
        drain();

        // Backpressure: result held, new input ignored
        out_ready = 1'b0;
        send(8'd5, 8'd10, 8'd20, 8'd251);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_out_valid_seen", out_valid, 1);
        a_in     = 8'd99;
        b_in     = 8'd33;
        w_in     = 8'd44;
        q        = 8'd251;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_a_out", a_out, 5);
            chk("bp_bw_out", bw_out, 200);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_valid", out_valid, 0);
        chk("bp_release_ready", in_ready, 1);
        repeat (12) @(negedge clk);
        chk("bp_no_phantom", out_valid, 0);

        // Reset mid-MUL aborts the operation
        send(8'd1, 8'd100, 8'd100, 8'd251);
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 0);
        sb.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        chk("abort_no_result", out_valid, 0);
        send(8'd2, 8'd7, 8'd9, 8'd251);
        drain();

        // Random operands with random output backpressure
        rand_bp = 1'b1;
        for (int i = 0; i < 200; i++) begin
            send(8'($urandom), 8'($urandom), 8'($urandom), 8'd251);
        end
        for (int i = 0; i < 40; i++) begin
            rq = 8'($urandom_range(64, 127) * 2 + 1);
            send(8'($urandom), 8'($urandom), 8'($urandom), rq);
        end
        @(negedge clk);
        rand_bp   = 1'b0;
        out_ready = 1'b1;
        drain();
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
